uart_rx: RTL
============

# uart_rx

Serial receiver for the UART datapath: samples the asynchronous `rx` line using the shared 16x oversampling tick `bclk`, recovers 8N1 frames (1 start, DATA_WIDTH data bits LSB-first, 1 stop), and presents each received word with a one-cycle `rx_done` strobe. It sits between the pad-side `rx` line and the RX FIFO write port. It uses the same baud generator and frame format as `uart_tx`.

## Interface
- DATA_WIDTH, 8, data bits per frame.
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- bclk  input  1  oversample tick: one-`clk` pulse, 16 per bit period.
- rx  input  1  asynchronous serial line, idle high.
- dout  output  DATA_WIDTH  last received word; holds until the next frame completes.
- rx_done  output  1  one-cycle strobe: `dout` valid, stop bit good.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer to `rx_s` before any use. `rx_s` resets high.
- `bclk_cnt` is 4 bits. `bit_idx` is $clog2(DATA_WIDTH) bits. Shift register `sh` is DATA_WIDTH bits.
- Counters and the shift register change only on cycles where `bclk`=1, except on the IDLE exit.
- RX_IDLE: on `rx_s`=0, go to RX_START and clear `bclk_cnt`.
- RX_START: on each tick, increment `bclk_cnt`. At `bclk_cnt`==7 (start-bit midpoint):
  - `rx_s`=0: go to RX_DATA, clear `bclk_cnt` and `bit_idx`.
  - `rx_s`=1: treat as a glitch and return to RX_IDLE.
- RX_DATA: on each tick, increment `bclk_cnt`. At `bclk_cnt`==15 (bit midpoint):
  - Shift: `sh` <= {`rx_s`, `sh`[DATA_WIDTH-1:1]}, so the word is received LSB-first.
  - Clear `bclk_cnt`.
  - If `bit_idx`==DATA_WIDTH-1, go to RX_STOP; otherwise increment `bit_idx`.
- RX_STOP: on each tick, increment `bclk_cnt`. At `bclk_cnt`==15:
  - `rx_s`=1: load `dout`<=`sh`, pulse `rx_done`, go to RX_IDLE.
  - `rx_s`=0: pulse `frame_err`, leave `dout` unchanged, go to RX_BREAK.
- RX_BREAK: wait for `rx_s`=1, then go to RX_IDLE. This prevents a held-low line from re-triggering a reception.
- `rx_done` and `frame_err` are never asserted together.

## Timing
- Reset values: state RX_IDLE, `dout`=0, `rx_done`=0, `frame_err`=0, `bclk_cnt`=0, `bit_idx`=0, `sh`=0.
- Reset takes effect at the next `clk` edge. Reset mid-frame abandons the frame with no strobe and returns to RX_IDLE.
- Falling edge on `rx` to RX_START: 3 `clk` cycles (2 synchronizer stages + 1 state register).
- All outputs are registered:
  - `rx_done` and `frame_err` are high for exactly the `clk` cycle after the stop-sample tick.
  - `dout` changes on the same edge that raises `rx_done`.
- Nominal frame length from start-bit edge to `rx_done`: 8 + 16·DATA_WIDTH + 16 ticks = 152 ticks for DATA_WIDTH=8, plus synchronizer and register latency.
- `rx_done` asserts mid-stop-bit. The receiver is ready for a new start edge from the next cycle, so back-to-back frames are accepted with no gap.
- `bclk` asserted on the same cycle as a state transition is consumed by the transition; no tick is lost or double-counted.
- There is no backpressure. The consumer must capture `dout` on the `rx_done` cycle.

## Structure
- `uart_pkg` gains `rx_state_e` {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK}.
- Reuse the existing `OS_16_BCLK_CNT` (=16) from `uart_pkg`. Add `OS_16_MID_CNT` (=7) to `uart_pkg`.
- One sub-module: `sync_2ff` (parameterized width, reset value 1) for the `rx` synchronizer.
- Next-state logic in a single combinational block; registers in one synchronous-reset block.

## Test plan
- Bench conditions for all scenarios: `bclk` every 4 `clk`; stimulus is a bit-accurate driver at 16 ticks/bit.
- Frame 0xA5, good stop -> exactly one `rx_done` pulse, `dout`=0xA5, `frame_err` never high.
- `rx` low for 4 ticks, then high -> no strobe, state back in RX_IDLE; a following 0x3C frame yields `dout`=0x3C.
- Frame 0x5A with stop bit driven low, line held low for 40 ticks, then high, then frame 0x81:
  - `frame_err` pulses once, `dout` stays at its prior value, no spurious start during the low hold;
  - the 0x81 frame yields `rx_done`, `dout`=0x81.
- Back-to-back frames 0x00, 0xFF, 0x55 with zero idle gap -> three `rx_done` pulses in order with `dout`=0x00, 0xFF, 0x55.
- `rst` asserted for 1 cycle during data bit 4 of 0xC3 -> no strobe, `dout`=0; a following 0x7E frame yields `dout`=0x7E.
- Loopback `uart_tx`→`uart_rx` sharing one `bclk`, 256 words 0x00–0xFF -> every word matches, 256 `rx_done`, 0 `frame_err`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and the receiver state encoding.
package uart_pkg;

    localparam int OS_16_BCLK_CNT = 16;
    localparam int OS_16_MID_CNT  = 7;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to RESET_VAL.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver using a 16x oversample tick; emits registered done/error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bclk,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rx_done,
    output logic                  frame_err
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [3:0]       MID_CNT  = 4'(OS_16_MID_CNT);
    localparam logic [3:0]       LAST_CNT = 4'(OS_16_BCLK_CNT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic                  w_rx_s;

    rx_state_e             r_state;
    logic [3:0]            r_bclk_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_sh;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_rx_done;
    logic                  r_frame_err;

    rx_state_e             w_state;
    logic [3:0]            w_bclk_cnt;
    logic [IDX_W-1:0]      w_bit_idx;
    logic [DATA_WIDTH-1:0] w_sh;
    logic [DATA_WIDTH-1:0] w_dout;
    logic                  w_rx_done;
    logic                  w_frame_err;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // A tick that lands on a decision cycle is spent by the transition itself.
    always_comb begin
        w_state     = r_state;
        w_bclk_cnt  = r_bclk_cnt;
        w_bit_idx   = r_bit_idx;
        w_sh        = r_sh;
        w_dout      = r_dout;
        w_rx_done   = 1'b0;
        w_frame_err = 1'b0;

        case (r_state)
            RX_IDLE: begin
                if (!w_rx_s) begin
                    w_state    = RX_START;
                    w_bclk_cnt = '0;
                end
            end

            RX_START: begin
                if (bclk) begin
                    if (r_bclk_cnt == MID_CNT) begin
                        if (!w_rx_s) begin
                            w_state    = RX_DATA;
                            w_bclk_cnt = '0;
                            w_bit_idx  = '0;
                        end else begin
                            w_state = RX_IDLE;
                        end
                    end else begin
                        w_bclk_cnt = r_bclk_cnt + 4'd1;
                    end
                end
            end

            RX_DATA: begin
                if (bclk) begin
                    if (r_bclk_cnt == LAST_CNT) begin
                        w_sh       = {w_rx_s, r_sh[DATA_WIDTH-1:1]};
                        w_bclk_cnt = '0;
                        if (r_bit_idx == LAST_IDX) begin
                            w_state = RX_STOP;
                        end else begin
                            w_bit_idx = r_bit_idx + 1'b1;
                        end
                    end else begin
                        w_bclk_cnt = r_bclk_cnt + 4'd1;
                    end
                end
            end

            RX_STOP: begin
                if (bclk) begin
                    if (r_bclk_cnt == LAST_CNT) begin
                        w_bclk_cnt = '0;
                        if (w_rx_s) begin
                            w_dout    = r_sh;
                            w_rx_done = 1'b1;
                            w_state   = RX_IDLE;
                        end else begin
                            w_frame_err = 1'b1;
                            w_state     = RX_BREAK;
                        end
                    end else begin
                        w_bclk_cnt = r_bclk_cnt + 4'd1;
                    end
                end
            end

            // A held-low line must return high before another start is accepted.
            RX_BREAK: begin
                if (w_rx_s) begin
                    w_state = RX_IDLE;
                end
            end

            default: begin
                w_state = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RX_IDLE;
            r_bclk_cnt  <= '0;
            r_bit_idx   <= '0;
            r_sh        <= '0;
            r_dout      <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_bclk_cnt  <= w_bclk_cnt;
            r_bit_idx   <= w_bit_idx;
            r_sh        <= w_sh;
            r_dout      <= w_dout;
            r_rx_done   <= w_rx_done;
            r_frame_err <= w_frame_err;
        end
    end

    assign dout      = r_dout;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;

endmodule
